// File: rtl/handshake_sink_if.sv
// Bus bundle for handshake_sink: async 4-phase req/ack with bundled data on the
// upstream side, valid/ready FIFO head on the consumer side.
interface handshake_sink_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic             req_in;
   logic             ack_out;
   logic [WIDTH-1:0] data_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [LVL_W-1:0] level;
   logic [15:0]      xfer_count;

   // slave: the sink itself; master: upstream stage plus downstream consumer
   modport slave (
      input  req_in, data_in, out_ready,
      output ack_out, out_valid, out_data, level, xfer_count
   );

   modport master (
      output req_in, data_in, out_ready,
      input  ack_out, out_valid, out_data, level, xfer_count
   );
endinterface

// File: rtl/handshake_sink.sv
// Clocked end-of-chain responder: synchronises a 4-phase req, captures bundled data into a
// first-word-fall-through FIFO. Define HS_SINK_COUNT_EN for the saturating transfer counter.
module handshake_sink #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst_n,
   handshake_sink_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StAcked,
      StRelease
   } state_e;

   state_e                 state_q;
   logic                   ack_q;
   logic [SYNC_STAGES-1:0] req_sync_q;
   logic                   req_s;
   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [LVL_W-1:0]       level_q;
   logic [WIDTH-1:0]       last_q;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_sync_q <= '0;
      end else begin
         req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.req_in};
      end
   end

   assign req_s      = req_sync_q[SYNC_STAGES-1];
   assign fifo_full  = (level_q == FULL_LVL);
   assign fifo_empty = (level_q == '0);
   // Full uses the registered level, so a pop frees the slot only for the next cycle
   assign push       = (state_q == StIdle) && req_s && !fifo_full;
   assign pop        = !fifo_empty && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ack_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (push) begin
                  state_q <= StAcked;
                  ack_q   <= 1'b1;
               end
            end
            StAcked: begin
               if (!req_s) begin
                  state_q <= StRelease;
                  ack_q   <= 1'b0;
               end
            end
            StRelease: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         last_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         unique case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

`ifdef HS_SINK_COUNT_EN
   logic [15:0] xfer_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_count_q <= '0;
      end else if (push && (xfer_count_q != 16'hFFFF)) begin
         xfer_count_q <= xfer_count_q + 16'd1;
      end
   end

   assign bus.xfer_count = xfer_count_q;
`else
   assign bus.xfer_count = 16'h0000;
`endif

   assign bus.ack_out   = ack_q;
   assign bus.out_valid = !fifo_empty;
   // When empty, keep showing the last word handed out
   assign bus.out_data  = fifo_empty ? last_q : mem_q[rd_ptr_q];
   assign bus.level     = level_q;

endmodule

// File: tb/tb_handshake_sink.sv
// Bench for handshake_sink: directed protocol scenarios plus a randomized stream, checked
// against a queue-based model of the words in flight.
module tb_handshake_sink;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SYNC  = 2;
   localparam int          LAT   = SYNC + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   handshake_sink_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   handshake_sink #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];   // words requested but not yet consumed, in order
   int pending = 0;        // requests raised but not yet acknowledged
   int model_xfer = 0;
   int popped = 0;
   bit rand_done = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_xfer();
`ifdef HS_SINK_COUNT_EN
      return (model_xfer > 65535) ? 32'd65535 : 32'(model_xfer);
`else
      return 32'd0;
`endif
   endfunction

   // Consumer-side model: level, valid and popped words follow the queue
   initial begin
      int exp_lvl;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_lvl = exp_q.size() - pending;
            check("level", bus.level, exp_lvl);
            check("out_valid", bus.out_valid, exp_lvl != 0);
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
               check("out_data", bus.out_data, exp_q.pop_front());
               popped++;
            end
         end
      end
   end

   task automatic raise_req(input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.data_in = d;
      bus.req_in  = 1'b1;
      exp_q.push_back(d);
      pending++;
   endtask

   task automatic wait_ack(input int budget, output int cyc);
      cyc = 0;
      while (bus.ack_out !== 1'b1 && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("ack_up", bus.ack_out, 1);
      if (bus.ack_out === 1'b1) begin
         pending--;
         model_xfer++;
      end
   endtask

   task automatic drop_req(input int budget, output int cyc);
      bus.req_in = 1'b0;
      cyc = 0;
      while (bus.ack_out !== 1'b0 && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("ack_down", bus.ack_out, 0);
   endtask

   task automatic send(input logic [7:0] d, input bit chk_lat, input int budget);
      int c;
      raise_req(d);
      wait_ack(budget, c);
      if (chk_lat) check("lat_up", c, LAT);
      drop_req(budget, c);
      if (chk_lat) check("lat_down", c, LAT);
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (bus.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      bus.out_ready = 1'b0;
      check("drained", bus.out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [7:0] d;
      bus.req_in    = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      #23;
      check("rst_ack", bus.ack_out, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_level", bus.level, 0);
      check("rst_xfer", bus.xfer_count, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single word
      raise_req(8'h5A);
      wait_ack(20, c);
      check("t1_lat", c, LAT);
      check("t1_valid", bus.out_valid, 1);
      check("t1_data", bus.out_data, 8'h5A);
      drop_req(10, c);
      check("t1_lat_down", c, LAT);
      drain();
      check("t1_hold", bus.out_data, 8'h5A);
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("t1_empty_ready", bus.level, 0);
      check("t1_hold2", bus.out_data, 8'h5A);

      // Fill, then backpressure on the 5th word
      for (int i = 1; i <= 4; i++) send(8'(i), 1, 20);
      check("t2_full", bus.level, 4);
      raise_req(8'h05);
      repeat (8) @(posedge clk);
      #1;
      check("t2_no_ack", bus.ack_out, 0);
      check("t2_level4", bus.level, 4);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("t2_level3", bus.level, 3);
      wait_ack(10, c);
      check("t2_lat_after_pop", c, 1);
      check("t2_level_again", bus.level, 4);
      check("t2_head", bus.out_data, 8'h02);
      drop_req(10, c);
      drain();

      // Push and pop in the same cycle at level 2
      send(8'hA1, 1, 20);
      send(8'hA2, 1, 20);
      raise_req(8'hA3);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("t4_ack", bus.ack_out, 1);
      check("t4_level", bus.level, 2);
      check("t4_head", bus.out_data, 8'hA2);
      wait_ack(5, c);
      drop_req(10, c);
      drain();

      // Reset mid-handshake with req held high
      raise_req(8'h77);
      wait_ack(20, c);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      pending    = 0;
      model_xfer = 0;
      #1;
      check("t5_ack_drop", bus.ack_out, 0);
      check("t5_level_rst", bus.level, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("t5_level0", bus.level, 0);
      exp_q.push_back(8'h77);
      pending = 1;
      wait_ack(20, c);
      check("t5_recapture_lat", c, LAT);
      check("t5_level1", bus.level, 1);
      check("t5_data", bus.out_data, 8'h77);
      drop_req(10, c);
      drain();
      check("t5_xfer", bus.xfer_count, exp_xfer());

      // Streaming with the consumer always ready
      popped = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) send(8'(i), 1, 20);
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("t3_popped", popped, 16);
      check("t3_model_empty", exp_q.size(), 0);
      check("t3_xfer", bus.xfer_count, exp_xfer());

      // Randomized words, gaps and consumer readiness
      popped = 0;
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               d = 8'($urandom);
               repeat ($urandom_range(0, 3)) @(posedge clk);
               send(d, 0, 300);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 2) == 0);
            end
         end
      join
      drain();
      check("rnd_popped", popped, 40);
      check("rnd_model_empty", exp_q.size(), 0);
      check("rnd_xfer", bus.xfer_count, exp_xfer());

`ifdef HS_SINK_COUNT_EN
      // Counter saturation
      force dut.xfer_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.xfer_count_q;
      #1;
      check("t6_preload", bus.xfer_count, 16'hFFFE);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 1, 20);
      bus.out_ready = 1'b0;
      check("t6_sat", bus.xfer_count, 16'hFFFF);
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
